// File: rtl/tl_sensor_cond.sv
// Vehicle-detector conditioning: four channels of sync -> debounce -> gap extension,
// with a per-channel max-green cap driven by the controller state.
`timescale 1ns/1ps
module tl_sensor_cond #(
    parameter int unsigned DB_LEN  = 4,
    parameter int unsigned GAP     = 8,
    parameter int unsigned MAX_GRN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] det,
    input  logic [2:0] Q,
    output logic       Ta,
    output logic       Tal,
    output logic       Tb,
    output logic       Tbl
);

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = $clog2(DB_LEN) + 1;
    localparam int unsigned GW  = $clog2(GAP + 1);
    localparam int unsigned MW  = $clog2(MAX_GRN + 1);

    logic [NCH-1:0] s1_q, s2_q;
    logic [NCH-1:0] db_q, db_d;
    logic [NCH-1:0] t_q, t_d;
    logic [DW-1:0]  dcnt_q [NCH];
    logic [DW-1:0]  dcnt_d [NCH];
    logic [GW-1:0]  gcnt_q [NCH];
    logic [GW-1:0]  gcnt_d [NCH];
    logic [MW-1:0]  mcnt_q [NCH];
    logic [MW-1:0]  mcnt_d [NCH];

    // Per-channel next-state: debounce, gap timer, max-green counter, output.
    always_comb begin
        db_d   = db_q;
        t_d    = '0;
        dcnt_d = dcnt_q;
        gcnt_d = gcnt_q;
        mcnt_d = mcnt_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DW'(DB_LEN - 1)) begin
                    db_d[i]   = s2_q[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end else begin
                dcnt_d[i] = '0;
            end

            if (db_q[i]) begin
                gcnt_d[i] = GW'(GAP);
            end else if (gcnt_q[i] != '0) begin
                gcnt_d[i] = gcnt_q[i] - GW'(1);
            end

            // Green states are the even encodings 000/010/100/110 in channel order.
            if (Q == 3'(2 * i)) begin
                if (mcnt_q[i] != MW'(MAX_GRN)) begin
                    mcnt_d[i] = mcnt_q[i] + MW'(1);
                end
            end else begin
                mcnt_d[i] = '0;
            end

            t_d[i] = (db_q[i] | (gcnt_q[i] != '0)) & (mcnt_q[i] != MW'(MAX_GRN));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            t_q    <= '0;
            dcnt_q <= '{default: '0};
            gcnt_q <= '{default: '0};
            mcnt_q <= '{default: '0};
        end else begin
            s1_q   <= det;
            s2_q   <= s1_q;
            db_q   <= db_d;
            t_q    <= t_d;
            dcnt_q <= dcnt_d;
            gcnt_q <= gcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign Ta  = t_q[0];
    assign Tal = t_q[1];
    assign Tb  = t_q[2];
    assign Tbl = t_q[3];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Directed bench for tl_sensor_cond; edges are counted from each reset release.
`timescale 1ns/1ps
module tb_tl_sensor_cond;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] det = 4'h0;
    logic [2:0] Q = 3'b000;
    logic       Ta, Tal, Tb, Tbl;

    int edge_n   = 0;
    int total    = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [3:0] seen;
    logic       allh;

    tl_sensor_cond dut (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det),
        .Q       (Q),
        .Ta      (Ta),
        .Tal     (Tal),
        .Tb      (Tb),
        .Tbl     (Tbl)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {Tbl, Tb, Tal, Ta};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic do_reset(input logic [3:0] d, input logic [2:0] q);
        reset_n = 1'b0;
        det     = d;
        Q       = q;
        tick();
        tick();
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset hold with all detectors active, then simultaneous rise.
        reset_n = 1'b0;
        det     = 4'hF;
        Q       = 3'b000;
        tick();
        check("rst_hold_a", outs(), 4'h0);
        tick();
        tick();
        check("rst_hold_b", outs(), 4'h0);
        reset_n = 1'b1;
        Q       = 3'b001;
        edge_n  = 0;
        wait_to(6);
        check("rst_rise_e6", outs(), 4'h0);
        wait_to(7);
        check("rst_rise_e7", outs(), 4'hF);

        // 3-cycle glitch rejected.
        do_reset(4'h0, 3'b001);
        det = 4'b0001;
        wait_to(3);
        det  = 4'h0;
        seen = 4'h0;
        repeat (30) begin
            tick();
            seen = seen | outs();
        end
        check("glitch3", seen, 4'h0);

        // Exactly DB_LEN-cycle pulse accepted, then gap tail.
        do_reset(4'h0, 3'b001);
        det = 4'b0001;
        wait_to(4);
        det = 4'h0;
        wait_to(6);
        check("pulse4_e6", outs(), 4'h0);
        wait_to(7);
        check("pulse4_e7", outs(), 4'b0001);
        wait_to(18);
        check("pulse4_e18", outs(), 4'b0001);
        wait_to(19);
        check("pulse4_e19", outs(), 4'h0);

        // 20-cycle press, short re-press filtered during the gap.
        do_reset(4'h0, 3'b001);
        det = 4'b0001;
        wait_to(6);
        check("gap_e6", outs(), 4'h0);
        wait_to(7);
        check("gap_e7", outs(), 4'b0001);
        wait_to(20);
        det = 4'h0;
        wait_to(27);
        det = 4'b0001;
        wait_to(29);
        det = 4'h0;
        wait_to(30);
        check("gap_e30", outs(), 4'b0001);
        wait_to(34);
        check("gap_e34", outs(), 4'b0001);
        wait_to(35);
        check("gap_e35", outs(), 4'h0);

        // Re-detection during the gap keeps T high without dropout.
        do_reset(4'h0, 3'b001);
        det = 4'b0001;
        wait_to(7);
        allh = Ta;
        while (edge_n < 40) begin
            tick();
            allh = allh & Ta;
            if (edge_n == 10) det = 4'h0;
            if (edge_n == 17) det = 4'b0001;
        end
        check("gap_extend", {3'b000, allh}, 4'b0001);

        // Max-green cap on ch2.
        do_reset(4'b0100, 3'b001);
        wait_to(7);
        check("max_e7", outs(), 4'b0100);
        wait_to(10);
        Q = 3'b100;
        wait_to(42);
        check("max_e42", outs(), 4'b0100);
        wait_to(43);
        check("max_e43", outs(), 4'h0);
        wait_to(50);
        check("max_e50", outs(), 4'h0);
        Q = 3'b101;
        wait_to(51);
        check("max_e51", outs(), 4'h0);
        wait_to(52);
        check("max_e52", outs(), 4'b0100);

        // Reset mid-gap discards the pending extension.
        do_reset(4'b0010, 3'b001);
        wait_to(7);
        check("rgap_e7", outs(), 4'b0010);
        wait_to(10);
        det = 4'h0;
        wait_to(14);
        check("rgap_e14", outs(), 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        check("rgap_async", outs(), 4'h0);
        tick();
        tick();
        reset_n = 1'b1;
        edge_n  = 0;
        seen    = 4'h0;
        repeat (30) begin
            tick();
            seen = seen | outs();
        end
        check("rgap_after", seen, 4'h0);

        // Independent channels ch1 and ch3.
        do_reset(4'h0, 3'b001);
        det = 4'b0010;
        wait_to(4);
        det = 4'b1010;
        wait_to(6);
        check("ind_e6", outs(), 4'b0000);
        wait_to(7);
        check("ind_e7", outs(), 4'b0010);
        wait_to(10);
        check("ind_e10", outs(), 4'b0010);
        wait_to(11);
        check("ind_e11", outs(), 4'b1010);
        wait_to(15);
        det = 4'b1000;
        wait_to(19);
        det = 4'h0;
        wait_to(29);
        check("ind_e29", outs(), 4'b1010);
        wait_to(30);
        check("ind_e30", outs(), 4'b1000);
        wait_to(33);
        check("ind_e33", outs(), 4'b1000);
        wait_to(34);
        check("ind_e34", outs(), 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/tl_sensor_cond.md
# tl_sensor_cond

Vehicle-detector conditioning block for the left-turn traffic light controller. It turns four raw, asynchronous loop-detector inputs into the clean traffic-present signals Ta, Tal, Tb and Tbl, which the controller's next-state logic consumes. Each channel has a synchroniser, a debounce filter and a gap-extension timer. A max-green cap watches the controller state and forces a channel's output low so that one approach cannot hold its green indefinitely.

## Interface
- DB_LEN, 4: consecutive synchronised cycles a detector level must hold before it is accepted (≥1).
- GAP, 8: cycles T stays high after the debounced detector drops (≥1).
- MAX_GRN, 32: cycles a phase may stay green before its T is forced low (≥1).
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- det  input  4  raw detectors, asynchronous: [0] A through, [1] A left, [2] B through, [3] B left.
- Q  input  3  controller state register, synchronous to clk.
- Ta  output  1  A-through traffic present, registered.
- Tal  output  1  A-left traffic present, registered.
- Tb  output  1  B-through traffic present, registered.
- Tbl  output  1  B-left traffic present, registered.

## Operation
- There are four identical channels, ch0..ch3, mapped to det[0..3] and to Ta, Tal, Tb, Tbl.
- Green-state mapping: ch0 = 3'b000, ch1 = 3'b010, ch2 = 3'b100, ch3 = 3'b110. Odd states are yellow and match no channel.
- **Synchroniser:** each detector passes through two flops (s1, s2).
- **Debounce:** each channel holds a stable level db and a counter dcnt of width clog2(DB_LEN)+1.
  - If s2 != db: dcnt increments. When dcnt == DB_LEN-1, db <= s2 and dcnt <= 0.
  - If s2 == db: dcnt <= 0.
  - Any agreeing cycle restarts the count.
- **Gap timer:** gcnt has width clog2(GAP+1).
  - If db = 1: gcnt <= GAP.
  - Else if gcnt != 0: gcnt decrements.
  - Otherwise gcnt holds at 0 (saturates, never wraps).
  - present = db | (gcnt != 0).
- **Max-green:** mcnt has width clog2(MAX_GRN+1).
  - If Q equals the channel's green state: mcnt increments, saturating at MAX_GRN.
  - Otherwise: mcnt <= 0.
  - maxout = (mcnt == MAX_GRN).
- **Output:** T <= present & ~maxout on every edge.
- Channels are fully independent, with no priority between them. Simultaneous activity on all four is legal.
- Reset behaviour:
  - All flops clear immediately on reset_n low: s1, s2, db, dcnt, gcnt, mcnt and the outputs.
  - Ta, Tal, Tb and Tbl are 0 during and after reset until the detector path fills.
  - Reset mid-debounce, mid-gap or mid-max-out discards all history.
- With every T at 0, the controller cycles through all phases. This is intended behaviour.

## Timing
All edge counts below assume default parameters.

- **Rise latency:** if det goes high before edge 1 and stays high, T rises at edge 3+DB_LEN (edge 7).
- **Fall latency:** if det goes low before edge n and stays low:
  - db falls at edge n+1+DB_LEN.
  - gcnt reaches 0 at edge n+1+DB_LEN+GAP.
  - T falls at edge n+2+DB_LEN+GAP (n+14).
- **Glitch rejection:** a pulse shorter than DB_LEN synchronised cycles never changes db or T. A pulse of exactly DB_LEN cycles is accepted.
- **Gap extension:** re-detection during the gap reloads gcnt, and T stays high without a dropout.
- **Max-out timing:**
  - If Q enters a green state after edge k, mcnt reaches MAX_GRN at edge k+MAX_GRN.
  - T is forced to 0 at edge k+MAX_GRN+1 and stays 0 while Q remains in that state.
  - If Q leaves after edge m, mcnt clears at edge m+1 and T may return high at edge m+2.
- Max-out overrides present. Debounce and gap counters keep running during max-out.
- State 000 is the controller's reset state, so ch0's mcnt starts counting on the first edge after reset release.

## Test plan
- **Reset:** hold reset_n low with det=4'hF and Q=000.
  - Ta, Tal, Tb and Tbl are 0 throughout reset.
  - After release with det=4'hF and Q=3'b001, all four rise together at edge 7.
- **Glitch:** det[0] high for 3 cycles, Q=3'b001 → Ta stays 0 for 30 cycles.
- **Pulse with gap:** det[0] high before edge 1 for 20 cycles, then low, Q=3'b001.
  - Ta rises at edge 7 and falls at edge 35.
  - A 2-cycle re-press at edge 28 produces no extension, because it is filtered by debounce.
- **Max-out:** det[2] held high, Q stepped to 3'b100 after edge 10.
  - Tb goes 0 at edge 43 and stays 0 while Q=100.
  - Q stepped to 3'b101 after edge 50 → Tb returns to 1 at edge 52.
- **Reset mid-gap:** det[1] drops, then reset_n pulses low 3 cycles later.
  - Tal goes 0 asynchronously.
  - After release with det[1]=0, Tal stays 0.
- **Independence:** det[1] and det[3] toggle at different times, Q=3'b001.
  - Each output matches its own channel's rise and fall latencies exactly.
  - Ta and Tb stay 0.
